// File: rtl/factor_witness_gen.sv
// Trial-division factor search: finds f1 <= f2 with f1*f2 == a using a restoring divider (requires W == 2*FW).
// Define FACTOR_WITNESS_ALL_EN to enumerate every factor pair followed by a found=0/last=1 terminator beat.
module factor_witness_gen #(
   parameter int W  = 10,
   parameter int FW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  a,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          found,
   output logic [FW-1:0] i1,
   output logic [FW-1:0] i2,
   output logic          last
);

   localparam int CW = $clog2(W + 1);
   localparam int DW = FW + 1;
   localparam int RW = FW + 2;
   localparam int SW = W + 1;
   localparam logic [DW-1:0] D_MAX    = {1'b0, {FW{1'b1}}};
   localparam logic [CW-1:0] CNT_LOAD = CW'(W);

`ifdef FACTOR_WITNESS_ALL_EN
   localparam bit ALL_EN = 1'b1;
`else
   localparam bit ALL_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_DIV,
      S_TEST,
      S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [DW-1:0]   d_q, d_d;
   logic [SW-1:0]   sq_q, sq_d;
   logic [RW-1:0]   rem_q, rem_d;
   logic [W-1:0]    quo_q, quo_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            found_q, found_d;
   logic [FW-1:0]   i1_q, i1_d;
   logic [FW-1:0]   i2_q, i2_d;
   logic            last_q, last_d;

   logic [RW-1:0]   rem_sh;
   logic [RW-1:0]   rem_step;
   logic [W-1:0]    quo_step;
   logic [SW-1:0]   sq_inc;

   // One restoring division step; the remainder never exceeds 2*d-1, so RW bits suffice.
   always_comb begin
      rem_sh   = {rem_q[RW-2:0], quo_q[W-1]};
      quo_step = {quo_q[W-2:0], 1'b0};
      rem_step = rem_sh;
      if (rem_sh >= {1'b0, d_q}) begin
         rem_step    = rem_sh - {1'b0, d_q};
         quo_step[0] = 1'b1;
      end
   end

   // (d+1)^2 = d^2 + 2d + 1 keeps the square without a multiplier.
   assign sq_inc = sq_q + {{(SW - DW - 1){1'b0}}, d_q, 1'b1};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      d_d     = d_q;
      sq_d    = sq_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      found_d = found_q;
      i1_d    = i1_q;
      i2_d    = i2_q;
      last_d  = last_q;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            d_d     = DW'(2);
            sq_d    = SW'(4);
            rem_d   = '0;
            quo_d   = a_q;
            cnt_d   = CNT_LOAD;
            state_d = S_DIV;
         end
         S_DIV: begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_TEST;
            end
         end
         S_TEST: begin
            if (sq_q > {1'b0, a_q} || d_q > D_MAX) begin
               found_d = 1'b0;
               i1_d    = '0;
               i2_d    = '0;
               last_d  = 1'b1;
               state_d = S_RESP;
            end else if (rem_q == '0 && quo_q[W-1:FW] == '0) begin
               found_d = 1'b1;
               i1_d    = d_q[FW-1:0];
               i2_d    = quo_q[FW-1:0];
               last_d  = !ALL_EN;
               state_d = S_RESP;
            end else begin
               d_d     = d_q + DW'(1);
               sq_d    = sq_inc;
               rem_d   = '0;
               quo_d   = a_q;
               cnt_d   = CNT_LOAD;
               state_d = S_DIV;
            end
         end
         S_RESP: begin
            if (out_ready) begin
               // A non-final pair resumes the search at the next candidate.
               if (ALL_EN && !last_q) begin
                  d_d     = d_q + DW'(1);
                  sq_d    = sq_inc;
                  rem_d   = '0;
                  quo_d   = a_q;
                  cnt_d   = CNT_LOAD;
                  state_d = S_DIV;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         d_q     <= '0;
         sq_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         found_q <= 1'b0;
         i1_q    <= '0;
         i2_q    <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         d_q     <= d_d;
         sq_q    <= sq_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         found_q <= found_d;
         i1_q    <= i1_d;
         i2_q    <= i2_d;
         last_q  <= last_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_RESP);
   assign found     = found_q;
   assign i1        = i1_q;
   assign i2        = i2_q;
   assign last      = last_q;

endmodule

// File: tb/tb_factor_witness_gen.sv
// Directed self-checking bench for factor_witness_gen (W=10, FW=5); honours FACTOR_WITNESS_ALL_EN.
module tb_factor_witness_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] a;
   logic       out_valid;
   logic       out_ready;
   logic       found;
   logic [4:0] i1;
   logic [4:0] i2;
   logic       last;

   int total = 0;
   int bad   = 0;

`ifdef FACTOR_WITNESS_ALL_EN
   localparam int PAIR_LAST = 0;
`else
   localparam int PAIR_LAST = 1;
`endif

   factor_witness_gen #(.W(10), .FW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .found     (found),
      .i1        (i1),
      .i2        (i2),
      .last      (last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_in_ready"},  32'(in_ready), 1);
      chk({tag, "_found"},     32'(found), 0);
      chk({tag, "_i1"},        32'(i1), 0);
      chk({tag, "_i2"},        32'(i2), 0);
      chk({tag, "_last"},      32'(last), 0);
   endtask

   task automatic send(input logic [9:0] av);
      int n = 0;
      while (!in_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_ready", 32'(in_ready), 1);
      in_valid = 1'b1;
      a        = av;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int exp_lat);
      int   n       = 0;
      logic busy_ok = 1'b1;
      while (!out_valid && n < 1000) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_busy"}, 32'(busy_ok), 1);
      if (exp_lat >= 0) chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
   endtask

   task automatic beat(input string tag, input int ef, input int e1, input int e2, input int el);
      chk({tag, "_found"}, 32'(found), 32'(ef));
      chk({tag, "_i1"},    32'(i1), 32'(e1));
      chk({tag, "_i2"},    32'(i2), 32'(e2));
      chk({tag, "_last"},  32'(last), 32'(el));
      $display("beat %s: found=%0d i1=%0d i2=%0d last=%0d", tag, found, i1, i2, last);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_drop"}, 32'(out_valid), 0);
   endtask

   task automatic req(input string tag, input logic [9:0] av, input int lat,
                      input int ef, input int e1, input int e2);
      send(av);
      wait_valid(tag, lat);
      if (ef == 1) begin
         beat(tag, 1, e1, e2, PAIR_LAST);
         if (PAIR_LAST == 0) begin
            chk({tag, "_resume_busy"}, 32'(in_ready), 0);
            wait_valid({tag, "_term"}, -1);
            beat({tag, "_term"}, 0, 0, 0, 1);
         end
      end else begin
         beat(tag, 0, 0, 0, 1);
      end
      chk({tag, "_idle"}, 32'(in_ready), 1);
   endtask

   initial begin
      logic stable_ok;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset");
      rst = 1'b0;

      req("a143",  10'd143,  111, 1, 11, 13);
      req("a62",   10'd62,   12,  1, 2,  31);
      req("a961",  10'd961,  331, 1, 31, 31);
      req("a4",    10'd4,    12,  1, 2,  2);
      req("a997",  10'd997,  342, 0, 0,  0);
      req("a1023", 10'd1023, 342, 0, 0,  0);
      req("a0",    10'd0,    12,  0, 0,  0);
      req("a1",    10'd1,    12,  0, 0,  0);
      req("a3",    10'd3,    12,  0, 0,  0);

`ifdef FACTOR_WITNESS_ALL_EN
      send(10'd60);
      wait_valid("all60_p2", 12);
      beat("all60_p2", 1, 2, 30, 0);
      chk("all60_p2_busy", 32'(in_ready), 0);
      wait_valid("all60_p3", 11);
      beat("all60_p3", 1, 3, 20, 0);
      wait_valid("all60_p4", 11);
      beat("all60_p4", 1, 4, 15, 0);
      wait_valid("all60_p5", 11);
      beat("all60_p5", 1, 5, 12, 0);
      wait_valid("all60_p6", 11);
      beat("all60_p6", 1, 6, 10, 0);
      wait_valid("all60_term", 22);
      beat("all60_term", 0, 0, 0, 1);
      chk("all60_idle", 32'(in_ready), 1);
`endif

      // Backpressure: result must hold while the consumer stalls.
      send(10'd143);
      wait_valid("bp143", 111);
      stable_ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (!(out_valid && found && i1 == 5'd11 && i2 == 5'd13 && !in_ready
               && last == 1'(PAIR_LAST))) stable_ok = 1'b0;
         @(posedge clk); #1;
      end
      chk("bp_stable", 32'(stable_ok), 1);
      $display("backpressure a=143: held 20 cycles, out_valid=%0d i1=%0d i2=%0d", out_valid, i1, i2);

      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_reset("rst_resp");

      send(10'd143);
      repeat (50) @(posedge clk);
      #1;
      chk("mid_div_busy", 32'(in_ready), 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_reset("rst_div");
      $display("reset mid-RESP and mid-DIV applied");

      req("after_rst62", 10'd62, 12, 1, 2, 31);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
